// File: rtl/mux_cfg_chain_tgate_ctrl.sv
// mux_cfg_chain_tgate_ctrl: scan-chain-programmed routing-mux select with shadow staging, legality check and one-hot TGATE drive
module mux_cfg_chain_tgate_ctrl #(
  parameter int NUM_INPUTS = 8,
  parameter bit ENCODED = 1'b0
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  ccff_head,
  input  logic                  cfg_en,
  input  logic                  cfg_commit,
  output logic                  ccff_tail,
  input  logic [NUM_INPUTS-1:0] in,
  output logic                  out,
  output logic [NUM_INPUTS-1:0] mem,
  output logic [NUM_INPUTS-1:0] mem_inv,
  output logic                  cfg_valid,
  output logic                  cfg_err
);
  localparam int SEL_W = $clog2(NUM_INPUTS);
  localparam int CFG_BITS = ENCODED ? SEL_W : NUM_INPUTS;
  localparam int CW = $clog2(CFG_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
  localparam logic [CW-1:0] CNT_OVER = CW'(CFG_BITS + 1);
  typedef enum logic [2:0] {EMPTY, LOADING, ACTIVE, RELOAD, ERROR} state_t;
  state_t state, state_nx;
  logic [CFG_BITS-1:0] shadow;
  logic [CW-1:0] bit_cnt;
  logic [NUM_INPUTS-1:0] dec;
  logic shape_ok, shift, legal;
  assign shift = cfg_en & ~cfg_commit;
  assign legal = cfg_commit & ~cfg_en & (bit_cnt == CNT_FULL) & shape_ok;
  generate
    if (ENCODED) begin : g_enc
      assign dec = NUM_INPUTS'(1) << shadow;
      assign shape_ok = {1'b0, shadow} < (SEL_W + 1)'(NUM_INPUTS);
    end else begin : g_hot
      assign dec = shadow;
      assign shape_ok = $onehot(shadow);
    end
  endgenerate
  // A same-cycle shift/commit collision is treated as a rejected commit
  always_comb begin
    state_nx = cfg_commit ? (legal ? ACTIVE : ERROR) : cfg_en ? (cfg_valid ? RELOAD : LOADING) : state;
  end
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= EMPTY;
      shadow <= '0;
      bit_cnt <= '0;
      ccff_tail <= 1'b0;
      mem <= '0;
      cfg_valid <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (shift) begin
        shadow <= CFG_BITS'({shadow, ccff_head});
        ccff_tail <= shadow[CFG_BITS-1];
        bit_cnt <= (bit_cnt == CNT_OVER) ? bit_cnt : bit_cnt + CW'(1);
      end
      if (cfg_commit) bit_cnt <= '0;
      if (legal) begin
        mem <= dec;
        cfg_valid <= 1'b1;
        cfg_err <= 1'b0;
      end else if (cfg_commit) cfg_err <= 1'b1;
    end
  end
  assign mem_inv = ~mem;
  assign out = |(in & mem);
endmodule

// File: tb/tb_mux_cfg_chain_tgate_ctrl.sv
// tb_mux_cfg_chain_tgate_ctrl: two chained one-hot slices plus one encoded 6-input slice against an arithmetic model
module tb_mux_cfg_chain_tgate_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] en = '0, cm = '0;
  logic hd_a = 1'b0, hd_e = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [5:0] in_e = '0;
  logic [2:0] tl_d, o_d, vl_d, er_d;
  logic [7:0] mem_a, mem_b, inv_a, inv_b;
  logic [5:0] mem_e, inv_e;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  mux_cfg_chain_tgate_ctrl #(.NUM_INPUTS(8), .ENCODED(1'b0)) dut_a (
    .prog_clk(clk), .pReset(rst), .ccff_head(hd_a), .cfg_en(en[0]), .cfg_commit(cm[0]),
    .ccff_tail(tl_d[0]), .in(in_a), .out(o_d[0]), .mem(mem_a), .mem_inv(inv_a),
    .cfg_valid(vl_d[0]), .cfg_err(er_d[0]));
  mux_cfg_chain_tgate_ctrl #(.NUM_INPUTS(8), .ENCODED(1'b0)) dut_b (
    .prog_clk(clk), .pReset(rst), .ccff_head(tl_d[0]), .cfg_en(en[1]), .cfg_commit(cm[1]),
    .ccff_tail(tl_d[1]), .in(in_b), .out(o_d[1]), .mem(mem_b), .mem_inv(inv_b),
    .cfg_valid(vl_d[1]), .cfg_err(er_d[1]));
  mux_cfg_chain_tgate_ctrl #(.NUM_INPUTS(6), .ENCODED(1'b1)) dut_e (
    .prog_clk(clk), .pReset(rst), .ccff_head(hd_e), .cfg_en(en[2]), .cfg_commit(cm[2]),
    .ccff_tail(tl_d[2]), .in(in_e), .out(o_d[2]), .mem(mem_e), .mem_inv(inv_e),
    .cfg_valid(vl_d[2]), .cfg_err(er_d[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: shadow held as an integer value, selection as an index
  int cb[3] = '{8, 8, 3};
  int ni[3] = '{8, 8, 6};
  int enc[3] = '{0, 0, 1};
  int shv[3] = '{0, 0, 0}, cnt[3] = '{0, 0, 0}, tl[3] = '{0, 0, 0};
  int sel[3] = '{0, 0, 0}, has[3] = '{0, 0, 0}, vl[3] = '{0, 0, 0}, er[3] = '{0, 0, 0};
  int hds[3];
  logic [7:0] ins[3], mems[3], invs[3], emem, mask;
  logic ok;
  initial forever begin
    @(posedge clk);
    hds = '{int'(hd_a), tl[0], int'(hd_e)};
    for (int s = 0; s < 3; s++) begin
      if (rst) begin
        shv[s] = 0; cnt[s] = 0; tl[s] = 0; sel[s] = 0; has[s] = 0; vl[s] = 0; er[s] = 0;
      end else if (en[s] && cm[s]) begin
        er[s] = 1; cnt[s] = 0;
      end else if (en[s]) begin
        tl[s] = (shv[s] >> (cb[s] - 1)) & 1;
        shv[s] = ((shv[s] << 1) | hds[s]) & ((1 << cb[s]) - 1);
        if (cnt[s] < cb[s] + 1) cnt[s]++;
      end else if (cm[s]) begin
        ok = (cnt[s] == cb[s]) && (enc[s] != 0 ? shv[s] < ni[s] : $countones(shv[s]) == 1);
        if (ok) begin
          sel[s] = enc[s] != 0 ? shv[s] : $clog2(shv[s]);
          has[s] = 1; vl[s] = 1; er[s] = 0;
        end else er[s] = 1;
        cnt[s] = 0;
      end
    end
    #1;
    ins = '{in_a, in_b, {2'b0, in_e}};
    mems = '{mem_a, mem_b, {2'b0, mem_e}};
    invs = '{inv_a, inv_b, {2'b0, inv_e}};
    for (int s = 0; s < 3; s++) begin
      mask = 8'((1 << ni[s]) - 1);
      emem = has[s] != 0 ? 8'(1 << sel[s]) : 8'h0;
      chk($sformatf("m%0d_mem", s), 32'(mems[s]), 32'(emem));
      chk($sformatf("m%0d_inv", s), 32'(invs[s]), 32'(~emem & mask));
      chk($sformatf("m%0d_out", s), 32'(o_d[s]), has[s] != 0 ? 32'(ins[s][sel[s]]) : 32'd0);
      chk($sformatf("m%0d_tail", s), 32'(tl_d[s]), 32'(tl[s]));
      chk($sformatf("m%0d_valid", s), 32'(vl_d[s]), 32'(vl[s]));
      chk($sformatf("m%0d_err", s), 32'(er_d[s]), 32'(er[s]));
    end
  end

  task automatic drive(input logic [2:0] e, input logic [2:0] c, input logic h);
    @(negedge clk);
    en = e; cm = c; hd_a = h; hd_e = h;
    #1;
  endtask
  task automatic shift(input logic [2:0] e, input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(e, 3'b000, v[i]);
  endtask
  task automatic commit(input logic [2:0] c);
    drive(3'b000, c, 1'b0);
    drive(3'b000, 3'b000, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = '0; cm = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] va, vb;
    va = 8'h08; vb = 8'h40;
    repeat (2) @(negedge clk);
    chk("rst_mem", 32'(mem_a), 32'h00);
    chk("rst_inv", 32'(inv_a), 32'hFF);
    chk("rst_out", 32'(o_d[0]), 32'd0);
    rst = 1'b0;
    // one-hot select 5
    in_a = 8'b1010_0110;
    shift(3'b001, 16'h20, 8);
    commit(3'b001);
    chk("t1_mem", 32'(mem_a), 32'h20);
    chk("t1_inv", 32'(inv_a), 32'hDF);
    chk("t1_out", 32'(o_d[0]), 32'd1);
    chk("t1_valid", 32'(vl_d[0]), 32'd1);
    in_a = 8'h5A; #1;
    chk("t1_out_comb", 32'(o_d[0]), 32'd0);
    // two bits set
    do_reset();
    in_a = 8'hFF;
    shift(3'b001, 16'h24, 8);
    commit(3'b001);
    chk("t2_err", 32'(er_d[0]), 32'd1);
    chk("t2_mem", 32'(mem_a), 32'h00);
    chk("t2_out", 32'(o_d[0]), 32'd0);
    chk("t2_valid", 32'(vl_d[0]), 32'd0);
    // reprogram while the old select keeps routing
    do_reset();
    in_a = 8'h20;
    shift(3'b001, 16'h20, 8);
    commit(3'b001);
    for (int i = 7; i >= 0; i--) begin
      drive(3'b001, 3'b000, i == 0);
      chk("t3_hold_out", 32'(o_d[0]), 32'd1);
      chk("t3_hold_mem", 32'(mem_a), 32'h20);
    end
    commit(3'b001);
    chk("t3_mem", 32'(mem_a), 32'h01);
    chk("t3_out", 32'(o_d[0]), 32'd0);
    // encoded N=6
    in_e = 6'b001000;
    shift(3'b100, 16'h6, 3);
    commit(3'b100);
    chk("t4_err", 32'(er_d[2]), 32'd1);
    chk("t4_mem0", 32'(mem_e), 32'h00);
    shift(3'b100, 16'h3, 3);
    commit(3'b100);
    chk("t4_mem", 32'(mem_e), 32'b001000);
    chk("t4_inv", 32'(inv_e), 32'b110111);
    chk("t4_out", 32'(o_d[2]), 32'd1);
    chk("t4_err2", 32'(er_d[2]), 32'd0);
    // over- and undershift
    do_reset();
    shift(3'b001, 16'h020, 9);
    commit(3'b001);
    chk("t5_over_err", 32'(er_d[0]), 32'd1);
    chk("t5_over_mem", 32'(mem_a), 32'h00);
    shift(3'b001, 16'h10, 7);
    commit(3'b001);
    chk("t5_under_err", 32'(er_d[0]), 32'd1);
    chk("t5_under_mem", 32'(mem_a), 32'h00);
    // reset mid-shift
    in_a = 8'hFF;
    shift(3'b001, 16'h20, 8);
    commit(3'b001);
    shift(3'b001, 16'hA, 4);
    @(negedge clk);
    en = '0; rst = 1'b1; #1;
    chk("t6_mem", 32'(mem_a), 32'h00);
    chk("t6_inv", 32'(inv_a), 32'hFF);
    chk("t6_out", 32'(o_d[0]), 32'd0);
    chk("t6_valid", 32'(vl_d[0]), 32'd0);
    chk("t6_tail", 32'(tl_d[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    shift(3'b001, 16'h04, 8);
    commit(3'b001);
    chk("t6_reload", 32'(mem_a), 32'h04);
    // chained slices: b's byte passes through a and its tail
    do_reset();
    shift(3'b001, 16'(vb), 8);
    commit(3'b001);
    drive(3'b001, 3'b000, va[7]);
    for (int i = 6; i >= 0; i--) drive(3'b011, 3'b000, va[i]);
    drive(3'b010, 3'b000, 1'b0);
    commit(3'b011);
    chk("t7_mem_a", 32'(mem_a), 32'h08);
    chk("t7_mem_b", 32'(mem_b), 32'h40);
    chk("t7_valid_b", 32'(vl_d[1]), 32'd1);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
